// File: rtl/csi2_raw10_40b_32b_gbx_pkg.sv
// Shared constants and types for the CSI-2 RAW10 gearboxes.
package csi2_raw10_40b_32b_gbx_pkg;

    localparam int unsigned RAW10_GRP_BYTES = 5;
    localparam int unsigned CSI2_WORD_BYTES = 4;
    localparam int unsigned BUF_BYTES       = 8;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned IN_W            = RAW10_GRP_BYTES * 8;
    localparam int unsigned OUT_W           = CSI2_WORD_BYTES * 8;

    typedef logic [7:0] byte_t;

    // Byte-enable mask for an output word given the number of buffered bytes.
    function automatic logic [CSI2_WORD_BYTES-1:0] keep_from_cnt(input logic [CNT_W-1:0] cnt);
        if (cnt >= CNT_W'(CSI2_WORD_BYTES)) begin
            return '1;
        end
        return 4'((4'h1 << cnt[1:0]) - 4'h1);
    endfunction

endpackage

// File: rtl/csi2_raw10_40b_32b_gbx_if.sv
// AXI4-Stream bundle used on both sides of the gearbox.
interface axi4_stream_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/csi2_raw10_40b_32b_gbx.sv
// TX RAW10 gearbox: repacks 5-byte pixel groups into 4-byte CSI-2 payload words,
// zero-padding and tkeep-flagging the short final word of a packet.
module csi2_raw10_40b_32b_gbx
    import csi2_raw10_40b_32b_gbx_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  pkt_i,
    axi4_stream_if.master pkt_o
);

    byte_t                      buf_q [BUF_BYTES];
    byte_t                      buf_d [BUF_BYTES];
    byte_t                      in_byte [BUF_BYTES];
    logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_pop;
    logic                       flush_q, flush_d;

    logic [OUT_W-1:0]           tdata_q, tdata_d;
    logic [CSI2_WORD_BYTES-1:0] tkeep_q, tkeep_d;
    logic                       tvalid_q, tvalid_d;
    logic                       tlast_q, tlast_d;

    logic                       pop, push, tready_c;

    assign pop      = tvalid_q & pkt_o.tready;
    assign tready_c = !rst_i & !flush_q &
                      ((cnt_q <= CNT_W'(3)) | (pop & (cnt_q <= CNT_W'(7))));
    assign push     = pkt_i.tvalid & tready_c;

    assign pkt_i.tready = tready_c;
    assign pkt_o.tdata  = tdata_q;
    assign pkt_o.tkeep  = tkeep_q;
    assign pkt_o.tvalid = tvalid_q;
    assign pkt_o.tlast  = tlast_q;

    // Unpack the input group; upper slots are padding so any 3-bit index stays in range.
    always_comb begin
        for (int k = 0; k < BUF_BYTES; k++) begin
            in_byte[k] = '0;
        end
        for (int k = 0; k < RAW10_GRP_BYTES; k++) begin
            in_byte[k] = pkt_i.tdata[8*k +: 8];
        end
    end

    // Buffer update: pop first, then append the new group behind what remains.
    always_comb begin
        for (int i = 0; i < BUF_BYTES; i++) begin
            buf_d[i] = buf_q[i];
        end
        cnt_pop = cnt_q;
        flush_d = flush_q;

        if (pop) begin
            if (tlast_q) begin
                for (int i = 0; i < BUF_BYTES; i++) begin
                    buf_d[i] = '0;
                end
                cnt_pop = '0;
                flush_d = 1'b0;
            end else begin
                for (int i = 0; i < CSI2_WORD_BYTES; i++) begin
                    buf_d[i] = buf_q[i + CSI2_WORD_BYTES];
                end
                for (int i = CSI2_WORD_BYTES; i < BUF_BYTES; i++) begin
                    buf_d[i] = '0;
                end
                cnt_pop = cnt_q - CNT_W'(CSI2_WORD_BYTES);
            end
        end

        cnt_d = cnt_pop;
        if (push) begin
            for (int j = 0; j < BUF_BYTES; j++) begin
                if ((CNT_W'(j) >= cnt_pop) && (CNT_W'(j) < cnt_pop + CNT_W'(RAW10_GRP_BYTES))) begin
                    buf_d[j] = in_byte[3'(CNT_W'(j) - cnt_pop)];
                end
            end
            cnt_d   = cnt_pop + CNT_W'(RAW10_GRP_BYTES);
            flush_d = pkt_i.tlast;
        end
    end

    // Output word derived from the next buffer state so it is registered with it.
    always_comb begin
        tvalid_d = (cnt_d >= CNT_W'(CSI2_WORD_BYTES)) | (flush_d & (cnt_d != '0));
        for (int i = 0; i < CSI2_WORD_BYTES; i++) begin
            tdata_d[8*i +: 8] = (CNT_W'(i) < cnt_d) ? buf_d[i] : '0;
        end
        tkeep_d = keep_from_cnt(cnt_d);
        tlast_d = flush_d & (cnt_d <= CNT_W'(CSI2_WORD_BYTES));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_BYTES; i++) begin
                buf_q[i] <= '0;
            end
            cnt_q    <= '0;
            flush_q  <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            for (int i = 0; i < BUF_BYTES; i++) begin
                buf_q[i] <= buf_d[i];
            end
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

endmodule
